// File: rtl/prog_clk_div_pkg.sv
// -----------------------------------------------------------------------------
// prog_clk_div_pkg
//
// Shared definitions for the programmable clock divider:
//   DEFAULT_DIV_C  - divisor loaded into every channel at reset (default value
//                    of the top-level DEFAULT_DIV parameter)
//   MAX_CH_C       - largest supported channel count
//   ch_w()         - width of the channel-index write port, max(1, clog2(n))
//   ch_act_e       - per-channel action decoded by the top each cycle
// -----------------------------------------------------------------------------
package prog_clk_div_pkg;

  localparam int unsigned DEFAULT_DIV_C = 250000;
  localparam int          MAX_CH_C      = 16;

  // A single-channel build still needs a 1-bit index port.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // What a channel does on the next falling edge when not in reset.
  // The top resolves write > halt > enable > count into one of these so the
  // channel itself needs no knowledge of the global controls.
  typedef enum logic [1:0] {
    CH_COUNT  = 2'd0,  // advance the counter, toggle at terminal count
    CH_OFF    = 2'd1,  // channel disabled: counter and output forced low
    CH_FREEZE = 2'd2,  // global halt: keep counter and output, no tick
    CH_LOAD   = 2'd3   // divisor write: load divisor, restart counter
  } ch_act_e;

endpackage

// File: rtl/prog_clk_divider_channel.sv
// -----------------------------------------------------------------------------
// div_channel
//
// One divider channel: divisor register, counter, square-wave output and
// toggle tick. All state changes on the falling edge of clk_i.
//
// Ports:
//   clk_i      in   clock (falling-edge active)
//   reset_ni   in   synchronous active-low reset
//   act_i      in   decoded action for this cycle (ch_act_e)
//   wr_data_i  in   divisor value used when act_i == CH_LOAD
//   clk_out_o  out  divided output, period 2*(div+1) advancing cycles
//   tick_o     out  one-cycle pulse on every clk_out_o toggle
// -----------------------------------------------------------------------------
module div_channel
  import prog_clk_div_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int unsigned RST_DIV = DEFAULT_DIV_C
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  ch_act_e          act_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] div_q,   div_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             clk_q,   clk_d;
  logic             tick_q,  tick_d;

  always_comb begin
    div_d   = div_q;
    count_d = count_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    unique case (act_i)
      CH_LOAD: begin
        // The new divisor takes effect from a fresh count; the output level
        // is kept so the waveform does not glitch on reprogramming.
        div_d   = wr_data_i;
        count_d = '0;
      end
      CH_FREEZE: begin
        // Everything holds; tick stays at its default of 0.
      end
      CH_OFF: begin
        count_d = '0;
        clk_d   = 1'b0;
      end
      CH_COUNT: begin
        // Equality compare on the full width: the counter restarts at the
        // divisor and therefore can never run past it or wrap.
        if (count_q == div_q) begin
          count_d = '0;
          clk_d   = ~clk_q;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(negedge clk_i) begin
    if (!reset_ni) begin
      div_q   <= WIDTH'(RST_DIV);
      count_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/prog_clk_divider.sv
// -----------------------------------------------------------------------------
// prog_clk_divider
//
// NUM_CH independent programmable clock dividers sharing one clock. Each
// channel produces a registered square wave with period 2*(div+1) clk cycles
// and a one-cycle tick on every toggle. State updates on the falling edge.
//
// Parameters:
//   NUM_CH       number of channels (1..16)
//   WIDTH        divisor / counter width
//   DEFAULT_DIV  divisor loaded into every channel at reset
//
// Ports:
//   clk      in   clock, falling-edge active
//   reset    in   synchronous active-low reset
//   halt     in   freezes every channel (count and clk_out held, tick low)
//   ch_en    in   per-channel enable; a disabled channel sits at 0
//   wr_en    in   divisor write strobe
//   wr_ch    in   channel index for the write; indices >= NUM_CH are ignored
//   wr_data  in   new divisor
//   step     in   single-step while halted (only with PROG_CLK_DIVIDER_STEP_EN)
//   clk_out  out  divided outputs
//   tick     out  toggle pulses
//
// Build option: define PROG_CLK_DIVIDER_STEP_EN to add the step input. When it
// is high during halt, every enabled channel advances once that cycle.
//
// Handshake: there is none; wr_en is a single-cycle strobe sampled on each
// falling edge, and a write always completes in the cycle it is presented.
// -----------------------------------------------------------------------------
module prog_clk_divider
  import prog_clk_div_pkg::*;
#(
  parameter  int          NUM_CH      = 4,
  parameter  int          WIDTH       = 32,
  parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_C,
  localparam int          CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_data,
`ifdef PROG_CLK_DIVIDER_STEP_EN
  input  logic              step,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic    freeze;
  ch_act_e act [NUM_CH];

  // A step request lifts the halt for exactly the cycle it is asserted.
`ifdef PROG_CLK_DIVIDER_STEP_EN
  assign freeze = halt & ~step;
`else
  assign freeze = halt;
`endif

  // Resolve write > halt > enable > count per channel. An out-of-range
  // wr_ch simply matches no channel, so such writes change nothing.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      act[c] = CH_COUNT;
      if (wr_en && (wr_ch == CH_W'(c))) begin
        act[c] = CH_LOAD;
      end else if (freeze) begin
        act[c] = CH_FREEZE;
      end else if (!ch_en[c]) begin
        act[c] = CH_OFF;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    div_channel #(
      .WIDTH   (WIDTH),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i     (clk),
      .reset_ni  (reset),
      .act_i     (act[g]),
      .wr_data_i (wr_data),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g])
    );
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_divider
//
// Directed bench for prog_clk_divider with NUM_CH=4, WIDTH=8, DEFAULT_DIV=3.
// The DUT acts on falling edges; inputs are driven and outputs sampled just
// after rising edges. A second 3-channel instance exercises an out-of-range
// write index, since index 5 does not fit the 2-bit port of the 4-channel
// instance.
// -----------------------------------------------------------------------------
module tb_prog_clk_divider;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       halt;
  logic [3:0] ch_en;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_data;
  logic [3:0] clk_out;
  logic [3:0] tick;

  logic       halt3;
  logic [2:0] ch_en3;
  logic       wr_en3;
  logic [1:0] wr_ch3;
  logic [2:0] clk_out3;
  logic [2:0] tick3;

`ifdef PROG_CLK_DIVIDER_STEP_EN
  logic step;
  logic step3;
`endif

  prog_clk_divider #(
    .NUM_CH      (4),
    .WIDTH       (8),
    .DEFAULT_DIV (3)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .halt    (halt),
    .ch_en   (ch_en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
`ifdef PROG_CLK_DIVIDER_STEP_EN
    .step    (step),
`endif
    .clk_out (clk_out),
    .tick    (tick)
  );

  prog_clk_divider #(
    .NUM_CH      (3),
    .WIDTH       (8),
    .DEFAULT_DIV (3)
  ) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .halt    (halt3),
    .ch_en   (ch_en3),
    .wr_en   (wr_en3),
    .wr_ch   (wr_ch3),
    .wr_data (wr_data),
`ifdef PROG_CLK_DIVIDER_STEP_EN
    .step    (step3),
`endif
    .clk_out (clk_out3),
    .tick    (tick3)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One DUT edge: the falling edge applies the inputs, the rising edge after
  // it is a quiet point to sample the registered outputs.
  task automatic next_edge();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic cyc(input string tag, input logic [3:0] exp_clk, input logic [3:0] exp_tick);
    next_edge();
    check({tag, " clk_out"}, clk_out, exp_clk);
    check({tag, " tick"}, tick, exp_tick);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] e_clk;
    logic [3:0] e_tick;

    reset   = 1'b0;
    halt    = 1'b0;
    ch_en   = 4'hF;
    wr_en   = 1'b0;
    wr_ch   = 2'd0;
    wr_data = 8'd0;
    halt3   = 1'b0;
    ch_en3  = 3'b111;
    wr_en3  = 1'b0;
    wr_ch3  = 2'd3;
`ifdef PROG_CLK_DIVIDER_STEP_EN
    step    = 1'b0;
    step3   = 1'b0;
`endif

    // Reset state.
    cyc("reset", 4'h0, 4'h0);
    check("reset3 clk_out", {1'b0, clk_out3}, 4'h0);
    check("reset3 tick", {1'b0, tick3}, 4'h0);

    // Free run at div=3: toggle every 4 edges, period 8, all in phase.
    // The 3-channel instance sees a continuous write to index 3 meanwhile.
    reset  = 1'b1;
    wr_en3 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      e_clk  = (((i / 4) % 2) == 1) ? 4'hF : 4'h0;
      e_tick = ((i % 4) == 0) ? 4'hF : 4'h0;
      cyc($sformatf("run e%0d", i), e_clk, e_tick);
      check($sformatf("oor e%0d clk_out", i), {1'b0, clk_out3}, e_clk & 4'h7);
      check($sformatf("oor e%0d tick", i), {1'b0, tick3}, e_tick & 4'h7);
    end
    wr_en3 = 1'b0;

    // Write ch2 div=0 mid-count: output holds, then toggles every edge.
    next_edge();
    next_edge();
    next_edge();
    cyc("pre wr2", 4'hF, 4'hF);
    next_edge();
    wr_en   = 1'b1;
    wr_ch   = 2'd2;
    wr_data = 8'd0;
    cyc("wr2 div0", 4'hF, 4'h0);
    wr_en   = 1'b0;
    cyc("div0 a", 4'b1011, 4'b0100);
    cyc("div0 b", 4'b0100, 4'b1111);
    cyc("div0 c", 4'b0000, 4'b0100);
    cyc("div0 d", 4'b0100, 4'b0100);

    // Reset mid-operation with other controls active; all divisors back to 3.
    reset   = 1'b0;
    halt    = 1'b1;
    ch_en   = 4'b1101;
    wr_en   = 1'b1;
    wr_ch   = 2'd0;
    wr_data = 8'd7;
    cyc("rst mid", 4'h0, 4'h0);
    reset   = 1'b1;
    halt    = 1'b0;
    ch_en   = 4'hF;
    wr_en   = 1'b0;
    cyc("post rst 1", 4'h0, 4'h0);
    cyc("post rst 2", 4'h0, 4'h0);
    cyc("post rst 3", 4'h0, 4'h0);
    cyc("post rst 4", 4'hF, 4'hF);

    // Halt for 10 edges at count 2, then resume at count 3.
    cyc("halt pre 1", 4'hF, 4'h0);
    cyc("halt pre 2", 4'hF, 4'h0);
    halt = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc($sformatf("halt %0d", i), 4'hF, 4'h0);
    end
    halt = 1'b0;
    cyc("resume cnt3", 4'hF, 4'h0);
    cyc("resume tc", 4'h0, 4'hF);

    // Write ch1 exactly at terminal count: ch1 neither toggles nor ticks.
    cyc("tc pre 1", 4'h0, 4'h0);
    cyc("tc pre 2", 4'h0, 4'h0);
    cyc("tc pre 3", 4'h0, 4'h0);
    wr_en   = 1'b1;
    wr_ch   = 2'd1;
    wr_data = 8'd3;
    cyc("wr at tc", 4'b1101, 4'b1101);
    wr_en   = 1'b0;

    // Disable ch3, write div=1 while disabled, re-enable.
    ch_en   = 4'b0111;
    cyc("ch3 off", 4'b0101, 4'h0);
    wr_en   = 1'b1;
    wr_ch   = 2'd3;
    wr_data = 8'd1;
    cyc("wr off ch3", 4'b0101, 4'h0);
    wr_en   = 1'b0;
    ch_en   = 4'hF;
    cyc("en e2", 4'b0101, 4'h0);
    cyc("en e3", 4'b1010, 4'hF);
    cyc("en e4", 4'b1010, 4'h0);
    cyc("en e5", 4'b0010, 4'b1000);

`ifdef PROG_CLK_DIVIDER_STEP_EN
    // Four step pulses while halted at div=3: one toggle, one tick.
    reset = 1'b0;
    cyc("step rst", 4'h0, 4'h0);
    reset = 1'b1;
    halt  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      e_clk = (k == 4) ? 4'hF : 4'h0;
      step  = 1'b1;
      cyc($sformatf("step %0d", k), e_clk, e_clk);
      step  = 1'b0;
      cyc($sformatf("step gap %0d", k), e_clk, 4'h0);
    end
    halt  = 1'b0;
`endif

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, divisor/counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 250000, divisor loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on falling edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port halt  input  1  global freeze of all channels.
REQ-007 SHALL have port ch_en  input  NUM_CH  per-channel enable.
REQ-008 SHALL have port wr_en  input  1  divisor write strobe.
REQ-009 SHALL have port wr_ch  input  CH_W (=max(1,clog2(NUM_CH)))  channel index for write.
REQ-010 SHALL have port wr_data  input  WIDTH  new divisor value.
REQ-011 SHALL have port step  input  1  single-step request; present only with PROG_CLK_DIVIDER_STEP_EN.
REQ-012 SHALL have port clk_out  output  NUM_CH  divided square-wave outputs, registered.
REQ-013 SHALL have port tick  output  NUM_CH  one-cycle pulse per clk_out toggle, registered.

Function
REQ-014 SHALL, per channel c when advancing: count==div[c] -> count<=0, clk_out[c] toggles, tick[c]<=1; else count<=count+1, tick[c]<=0.
REQ-015 SHALL give clk_out[c] period 2*(div[c]+1) clk cycles; div=0 toggles every cycle.
REQ-016 SHALL advance channel c only when reset=1, halt=0, ch_en[c]=1.
REQ-017 SHALL, with ch_en[c]=0, hold count[c]=0, clk_out[c]=0, tick[c]=0.
REQ-018 SHALL, with halt=1, hold count and clk_out of all channels and drive tick=0.
REQ-019 SHALL, on wr_en=1 with wr_ch<NUM_CH, load div[wr_ch]<=wr_data, clear count[wr_ch] to 0, hold clk_out[wr_ch], drive tick[wr_ch]=0 that cycle.
REQ-020 SHALL ignore writes with wr_ch>=NUM_CH; no state changes.
REQ-021 SHALL accept writes while halt=1 or ch_en[c]=0.
REQ-022 SHALL give write priority over terminal count in the same cycle: no toggle, no tick.
REQ-023 SHALL apply precedence reset > write > halt > ch_en > count.
REQ-024 SHALL keep counter compare full-width; count never exceeds div (no wrap past 2^WIDTH-1).

Reset
REQ-025 SHALL, on falling edge with reset=0, set every count=0, clk_out=0, tick=0, div=DEFAULT_DIV, regardless of other inputs.
REQ-026 SHALL, after reset, let first clk_out rise DEFAULT_DIV+1 advancing cycles after release.

Configuration
REQ-027 SHALL, with PROG_CLK_DIVIDER_STEP_EN defined, provide step; while halt=1, step=1 advances each enabled channel exactly once per cycle per REQ-014.
REQ-028 SHALL, without PROG_CLK_DIVIDER_STEP_EN, omit step; halt unconditionally freezes per REQ-018.

Structure
REQ-029 SHALL place DEFAULT_DIV default, max channel count, and CH_W width function in package prog_clk_div_pkg.
REQ-030 SHALL implement one channel as sub-module div_channel (count, div, clk_out, tick), instantiated NUM_CH times via generate; top holds write decode and halt/step gating.

Verification
REQ-031 SHALL cover: NUM_CH=4, WIDTH=8, DEFAULT_DIV=3, all enabled -> clk_out period 8 cycles, tick every 4 cycles, all in phase.
REQ-032 SHALL cover: write ch2 div=0 mid-count -> count2 cleared, clk_out2 holds, then toggles every cycle; other channels unaffected.
REQ-033 SHALL cover: halt=1 for 10 cycles at count=2 -> count/clk_out frozen, tick=0; resumes at count 3 after release.
REQ-034 SHALL cover: write at cycle count==div, and write wr_ch=5 with NUM_CH=4 -> no toggle/tick; out-of-range write changes nothing.
REQ-035 SHALL cover: reset=0 mid-operation with ch_en=0 on ch1 and wr_en=1 -> all outputs 0, all div=3 next edge.
REQ-036 SHALL cover, with STEP_EN: halt=1, four step pulses at div=3 -> exactly one toggle and one tick per channel.
